// File: rtl/unidad_ejecucion.sv
// unidad_ejecucion: fetch/execute/writeback unit feeding the 16-entry register bank (flags via UNIDAD_EJECUCION_FLAGS_EN)
module unidad_ejecucion #(
  parameter int N = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [3:0]    src_a,
  input  logic [3:0]    src_b,
  input  logic [3:0]    dst,
  input  logic [16*N-1:0] regs,
  output logic          w,
  output logic [3:0]    select_register,
  output logic [N-1:0]  s,
  output logic          busy,
`ifdef UNIDAD_EJECUCION_FLAGS_EN
  output logic          zero,
  output logic          carry,
`endif
  output logic          done
);
  localparam int CW = $clog2(N);
`ifdef UNIDAD_EJECUCION_FLAGS_EN
  localparam int AW = 2 * N;
`else
  localparam int AW = N;
`endif
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, DONE} state_t;
  state_t        state_q;
  logic [2:0]    op_q;
  logic [3:0]    src_a_q, src_b_q, dst_q;
  logic [N-1:0]  a_q, b_q;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q;
  logic [N:0]    alu, sl, sr;
  logic          last;
  assign busy = state_q != IDLE;
  // bit N of alu carries the carry/borrow/shifted-out bit alongside the N-bit result
  always_comb begin
    acc_d = acc_q + (b_q[cnt_q] ? (AW'(a_q) << cnt_q) : '0);
    sl    = {1'b0, a_q} << b_q[3:0];
    sr    = {a_q, 1'b0} >> b_q[3:0];
    alu   = op_q == 3'd0 ? {1'b0, a_q} + {1'b0, b_q} :
            op_q == 3'd1 ? {1'b0, a_q} - {1'b0, b_q} :
            op_q == 3'd2 ? {1'b0, a_q & b_q} :
            op_q == 3'd3 ? {1'b0, a_q | b_q} :
            op_q == 3'd4 ? {1'b0, a_q ^ b_q} :
            op_q == 3'd5 ? sl :
            op_q == 3'd6 ? {sr[0], sr[N:1]} :
                           {1'b0, acc_d[N-1:0]};
    last  = op_q != 3'd7 || cnt_q == CW'(N - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      op_q            <= '0;
      src_a_q         <= '0;
      src_b_q         <= '0;
      dst_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      acc_q           <= '0;
      cnt_q           <= '0;
      w               <= 1'b0;
      select_register <= '0;
      s               <= '0;
      done            <= 1'b0;
`ifdef UNIDAD_EJECUCION_FLAGS_EN
      zero            <= 1'b0;
      carry           <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_q    <= op;
          src_a_q <= src_a;
          src_b_q <= src_b;
          dst_q   <= dst;
          state_q <= FETCH;
        end
        FETCH: begin
          a_q     <= regs[src_a_q*N +: N];
          b_q     <= regs[src_b_q*N +: N];
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= EXEC;
        end
        EXEC: begin
          if (op_q == 3'd7) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
          end
          if (last) begin
            w               <= 1'b1;
            select_register <= dst_q;
            s               <= alu[N-1:0];
            state_q         <= WB;
`ifdef UNIDAD_EJECUCION_FLAGS_EN
            zero            <= alu[N-1:0] == '0;
            carry           <= op_q == 3'd7 ? |acc_d[AW-1:N] : alu[N];
`endif
          end
        end
        WB: begin
          w       <= 1'b0;
          done    <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_unidad_ejecucion.sv
// tb_unidad_ejecucion: scoreboard bench for unidad_ejecucion writebacks, latency, ignored starts and aborts
module tb_unidad_ejecucion;
  localparam int N = 16;
  logic clk = 0, rst = 1, start = 0;
  logic [2:0] op = '0;
  logic [3:0] src_a = '0, src_b = '0, dst = '0;
  logic [N-1:0] rb [16];
  logic [16*N-1:0] regs;
  logic w, busy, done;
  logic [3:0] select_register;
  logic [N-1:0] s;
`ifdef UNIDAD_EJECUCION_FLAGS_EN
  logic zero, carry;
`endif
  typedef struct {logic [3:0] d; logic [N-1:0] v;} exp_t;
  exp_t sb [$];
  int checks = 0, passed = 0, wcount = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 16; g++) begin : g_regs
    assign regs[g*N +: N] = rb[g];
  end
  unidad_ejecucion #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
    .regs(regs), .w(w), .select_register(select_register), .s(s), .busy(busy),
`ifdef UNIDAD_EJECUCION_FLAGS_EN
    .zero(zero), .carry(carry),
`endif
    .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [N-1:0] model(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] p;
    p = a * b;
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[3:0];
      3'd6: return a >> b[3:0];
      default: return p[N-1:0];
    endcase
  endfunction
  always @(negedge clk) begin
    if (!rst && w) begin
      wcount++;
      if (sb.size() == 0) chk("spurious_w", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_sel", select_register, e.d);
        chk("wb_data", s, e.v);
      end
    end
  end
  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, input bit push);
    @(negedge clk);
    op = o; src_a = a; src_b = b; dst = d; start = 1;
    if (push) sb.push_back('{d, model(o, rb[a], rb[b])});
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic await_done(input int exp_w);
    int wc, dc, nb;
    wc = 0; dc = 0; nb = 0;
    for (int c = 1; c <= 40 && dc == 0; c++) begin
      @(negedge clk);
      if (w && wc == 0) wc = c;
      if (!busy) nb++;
      if (done) dc = c;
    end
    chk("latency_w", wc, exp_w);
    chk("latency_done", dc, exp_w + 1);
    chk("busy_held", nb, 0);
  endtask
  task automatic run(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    issue(o, a, b, d, 1);
    await_done(o == 3'd7 ? N + 2 : 3);
  endtask
  initial begin
    int w0;
    for (int i = 0; i < 16; i++) rb[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_w", w, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_sel", select_register, 0);
    rst = 0;
    rb[0] = 16'h0001; rb[1] = 16'h0001;
    run(3'd0, 4'd0, 4'd1, 4'd4);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("idle_rst_w", w, 0);
    chk("idle_rst_busy", busy, 0);
    chk("idle_rst_done", done, 0);
    chk("idle_rst_s", s, 0);
    chk("idle_rst_sel", select_register, 0);
    @(negedge clk) rst = 0;
    rb[2] = 16'h0000; rb[3] = 16'h0001;
    run(3'd1, 4'd2, 4'd3, 4'd5);
`ifdef UNIDAD_EJECUCION_FLAGS_EN
    chk("sub_carry", carry, 1);
    chk("sub_zero", zero, 0);
`endif
    rb[4] = 16'h0404; rb[5] = 16'h0004;
    run(3'd7, 4'd4, 4'd5, 4'd6);
    for (int k = 0; k < 16; k++) begin
      rb[6 + (k % 8)] = N'($urandom);
      rb[14] = N'($urandom_range(0, 15));
      run(3'(k % 8), 4'($urandom_range(6, 13)), k[0] ? 4'd14 : 4'($urandom_range(6, 13)), 4'($urandom_range(6, 13)));
    end
    w0 = wcount;
    issue(3'd7, 4'd4, 4'd5, 4'd7, 1);
    repeat (3) @(negedge clk);
    start = 1; op = 3'd0; dst = 4'd9; rb[4] = 16'hFFFF;
    @(posedge clk);
    #1 start = 0;
    for (int c = 0; c < 40 && !done; c++) @(negedge clk);
    rb[4] = 16'h0404;
    repeat (8) @(negedge clk);
    chk("busy_start_one_w", wcount - w0, 1);
    run(3'd0, 4'd0, 4'd1, 4'd8);
    start = 1; op = 3'd0; src_a = 4'd0; src_b = 4'd1; dst = 4'd10;
    @(posedge clk);
    #1 start = 0;
    w0 = wcount;
    repeat (8) @(negedge clk);
    chk("done_start_ignored", wcount - w0, 0);
    run(3'd0, 4'd0, 4'd1, 4'd10);
    w0 = wcount;
    issue(3'd7, 4'd4, 4'd5, 4'd11, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_w", w, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk) rst = 0;
    repeat (25) @(negedge clk);
    chk("abort_no_w", wcount - w0, 0);
    run(3'd0, 4'd0, 4'd1, 4'd12);
    w0 = wcount;
    issue(3'd0, 4'd0, 4'd1, 4'd13, 0);
    @(posedge clk);
    @(posedge clk);
    #1 chk("wb_pre_abort_w", w, 1);
    rst = 1;
    #1 chk("wb_abort_w", w, 0);
    @(negedge clk) rst = 0;
    repeat (6) @(negedge clk);
    chk("wb_abort_no_w", wcount - w0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/unidad_ejecucion.md
Name: unidad_ejecucion

Overview:
- Sequential execution unit directly upstream of the 16-entry register bank.
- Reads the bank's 16 parallel outputs (flattened) and takes one operation command.
- Computes a result, either single-cycle or iterative multiply.
- Writes the result back through the bank's write port (w, select_register, s) for exactly one cycle.

Parameters:
- N, 16, data width; must match the register bank width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  command strobe; accepted only in IDLE.
- op  input  3  operation code (see Behaviour).
- src_a  input  4  index of operand A (0 = r1 … 15 = r16).
- src_b  input  4  index of operand B.
- dst  input  4  destination index for writeback.
- regs  input  16*N  register bank outputs; r1 at bits [N-1:0], r16 at bits [16N-1:15N].
- w  output  1  write enable to the register bank.
- select_register  output  4  write index to the register bank.
- s  output  N  write data to the register bank.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after writeback.

Behaviour:
- Reset (async): state=IDLE; w=0, select_register=0, s=0, busy=0, done=0; internal A, B, result, count cleared.
- FSM states: IDLE, FETCH, EXEC, WB, DONE.
- IDLE:
  - If start=1, latch op, src_a, src_b, dst, then go to FETCH.
  - If start=0, stay in IDLE.
- FETCH: A <= regs slice[src_a]; B <= regs slice[src_b]; go to EXEC.
- EXEC, single-cycle ops (one EXEC cycle; result registered):
  - 000 ADD: A+B
  - 001 SUB: A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: A << B[3:0]
  - 110 SHR: A >> B[3:0], logical
- EXEC, 111 MUL: shift-add, one multiplier bit per cycle, exactly N EXEC cycles.
  - count runs 0..N-1.
  - result = low N bits of A*B.
- Arithmetic: all results modulo 2^N; overflow wraps silently.
- WB: exactly one cycle with w=1, select_register=dst, s=result. The bank captures at the clock edge ending WB. Then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Outputs outside WB:
  - w=0 in every other state.
  - s and select_register hold their last driven values.
- Latency:
  - Non-MUL: start sampled at edge 0; w high during cycle 3 (FETCH, EXEC, WB); done in cycle 4.
  - MUL: w high during cycle N+2.
- Boundary conditions:
  - start while busy=1: ignored; no queuing.
  - start in the same cycle as DONE: ignored; re-issue is accepted in IDLE.
  - dst equal to src_a or src_b: legal; operands already latched in FETCH, so no hazard.
  - Shift amount B[3:0] ≥ N (only possible if N<16): result 0.
  - rst asserted mid-operation (including during WB): immediate IDLE, w=0, no write completes after reset deasserts.
- Operands are sampled only in FETCH; changes on regs during EXEC do not affect the result.

Optional Feature:
- Macro: UNIDAD_EJECUCION_FLAGS_EN
- Defined: adds outputs zero (1 bit) and carry (1 bit), updated at the edge entering WB and held until the next WB; both reset to 0.
  - zero = (result==0).
  - carry = carry-out for ADD, borrow (A<B) for SUB, last bit shifted out for SHL/SHR, any nonzero high-half bit for MUL, 0 for logic ops.
- Undefined: ports zero/carry absent; no flag logic.

Test Plan:
- Reset: assert rst mid-idle -> w=0, busy=0, done=0, s=0, select_register=0 immediately, without waiting for a clock edge.
- ADD: regs r1=0x0001, r2=0x0001; start with op=000, src_a=0, src_b=1, dst=4 -> w=1, select_register=4'b0100, s=0x0002 in cycle 3; done in cycle 4.
- SUB wrap: A=0x0000, B=0x0001 -> s=0xFFFF.
  - With FLAGS_EN: carry=1, zero=0.
- MUL: A=0x0404, B=0x0004 (N=16) -> s=0x1010; w asserted exactly in cycle 18; busy high cycles 1-18.
- Ignored start: pulse start again during EXEC of a MUL -> only one w pulse; second command never executes.
- Abort: assert rst during EXEC of a MUL -> state IDLE, no w pulse occurs; a subsequent ADD completes normally.
